// File: rtl/play_link_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : play_link_ctrl_pkg
//  Purpose  : Shared definitions for the play-link master/slave boards:
//             controller state encoding, link-word field positions and a
//             helper that packs a link word.
//  Revision : 1.0  initial release
// ============================================================================
package play_link_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        PLAY   = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam int LINK_W    = 4;
    localparam int PLAY_BIT  = 3;
    localparam int LEVEL_MSB = 2;
    localparam int SEC_W     = 10;

    localparam logic [LEVEL_MSB:0] LEVEL_MAX = '1;

    // Pack a cross-board word from the play flag and a level value.
    function automatic logic [LINK_W-1:0] make_link(input logic play,
                                                    input logic [LEVEL_MSB:0] lvl);
        logic [LINK_W-1:0] word;
        word              = '0;
        word[PLAY_BIT]    = play;
        word[LEVEL_MSB:0] = lvl;
        return word;
    endfunction

endpackage
`default_nettype wire

// File: rtl/play_link_ctrl_sec_timer.sv
`default_nettype none
// ============================================================================
//  Module   : play_link_ctrl_sec_timer
//  Purpose  : Elapsed-seconds timer. Divides clk by CLK_HZ while enabled and
//             counts whole seconds, saturating at the top of the sec range.
//             clear has priority over enable.
//  Revision : 1.0  initial release
// ============================================================================
module play_link_ctrl_sec_timer
    import play_link_ctrl_pkg::*;
#(
    parameter int CLK_HZ = 100000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       clear,
    output logic [9:0] sec
);

    localparam int              CNT_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_HZ - 1);
    localparam logic [SEC_W-1:0] SEC_MAX  = '1;

    logic [CNT_W-1:0] cnt;

    // Sub-second prescaler and saturating seconds count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            sec <= '0;
        end else if (clear) begin
            cnt <= '0;
            sec <= '0;
        end else if (enable) begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                if (sec != SEC_MAX) begin
                    sec <= sec + 1'b1;
                end
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/play_link_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : play_link_ctrl
//  Purpose  : Play-session controller driving a 4-bit cross-board link word
//             (play flag + level). Every link_out change is spaced at least
//             HOLD_CYC cycles from the previous one, except the forced clear
//             on session end. Sessions end on stop or on reaching max_sec.
//  Revision : 1.0  initial release
// ============================================================================
module play_link_ctrl
    import play_link_ctrl_pkg::*;
#(
    parameter int CLK_HZ   = 100000000,
    parameter int HOLD_CYC = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       level_up,
    input  logic       level_down,
    input  logic [9:0] max_sec,
    output logic [3:0] link_out,
    output logic       busy,
    output logic [9:0] sec,
    output logic       done
);

    // Hold counter saturates at HOLD_CYC-1, which always fits in clog2 bits.
    localparam int               HOLD_W    = $clog2(HOLD_CYC);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);

    state_t              state;
    state_t              state_nxt;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [HOLD_W-1:0]   hold_nxt;
    logic                hold_ok;
    logic [LEVEL_MSB:0]  level;
    logic [LINK_W-1:0]   link_nxt;
    logic                done_nxt;
    logic                timer_en;
    logic                timer_clr;
    logic                session_end;

    assign hold_ok     = (hold_cnt >= HOLD_LAST);
    assign session_end = stop || ((max_sec != '0) && (sec == max_sec));

    // Next-state, next link word and hold-counter bookkeeping.
    always_comb begin
        state_nxt = state;
        link_nxt  = link_out;
        hold_nxt  = hold_ok ? hold_cnt : hold_cnt + 1'b1;
        done_nxt  = 1'b0;
        timer_en  = 1'b0;
        timer_clr = 1'b0;
        case (state)
            IDLE: begin
                timer_clr = 1'b1;
                if (start && !stop) begin
                    state_nxt = ARM;
                    hold_nxt  = '0;
                end
            end
            ARM: begin
                if (stop) begin
                    state_nxt = FINISH;
                    link_nxt  = '0;
                    hold_nxt  = '0;
                    done_nxt  = 1'b1;
                end else if (hold_ok) begin
                    state_nxt = PLAY;
                    link_nxt  = make_link(1'b1, level);
                    hold_nxt  = '0;
                end
            end
            PLAY: begin
                if (session_end) begin
                    // Forced clear on exit ignores the hold spacing.
                    state_nxt = FINISH;
                    link_nxt  = '0;
                    hold_nxt  = '0;
                    done_nxt  = 1'b1;
                end else begin
                    timer_en = 1'b1;
                    // A pending level is published once the hold window expires.
                    if (hold_ok && (link_out[LEVEL_MSB:0] != level)) begin
                        link_nxt = make_link(1'b1, level);
                        hold_nxt = '0;
                    end
                end
            end
            FINISH: begin
                if (hold_ok) begin
                    state_nxt = IDLE;
                    timer_clr = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Controller registers; all outputs come straight from flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            hold_cnt <= '0;
            link_out <= '0;
            done     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
            link_out <= link_nxt;
            done     <= done_nxt;
            busy     <= (state_nxt != IDLE);
        end
    end

    // Saturating level register; simultaneous up/down cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= '0;
        end else if (level_up && !level_down && (level != LEVEL_MAX)) begin
            level <= level + 1'b1;
        end else if (level_down && !level_up && (level != '0)) begin
            level <= level - 1'b1;
        end
    end

    play_link_ctrl_sec_timer #(
        .CLK_HZ (CLK_HZ)
    ) sec_timer (
        .clk    (clk),
        .rst    (rst),
        .enable (timer_en),
        .clear  (timer_clr),
        .sec    (sec)
    );

endmodule
`default_nettype wire
